// File: rtl/trng_link_pkg.sv
// Shared definitions for producers of the packet_com serial link.
// Holds the arbiter state encoding, the link's largest packet size and a size check.
// No ports, no timing of its own.
package trng_link_pkg;

  localparam int MAX_PACKET_SIZE = 127;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    DRAIN
  } arb_state_t;

  // A zero-size packet is never worth granting the link for.
  function automatic logic size_ok(input logic [6:0] size);
    return (size != 7'd0) && (int'(size) <= MAX_PACKET_SIZE);
  endfunction

endpackage

// File: rtl/trng_link_arbiter_if.sv
// Bundle of producer-side and link-side signals of trng_link_arbiter.
// master: producers + packet_com (drive i_*); slave: the arbiter (drives o_*).
// No logic, zero latency; o_ready is the producers' byte backpressure.
interface trng_link_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   i_req;
  logic [7*N_REQ-1:0] i_size;
  logic [8*N_REQ-1:0] i_dat;
  logic [N_REQ-1:0]   i_write;
  logic [N_REQ-1:0]   o_grant;
  logic [N_REQ-1:0]   o_ready;
  logic [N_REQ-1:0]   o_done;
  logic [N_REQ-1:0]   o_timeout;
  logic               o_start_packet;
  logic [6:0]         o_packet_size;
  logic [7:0]         o_link_dat;
  logic               o_link_write;
  logic               i_link_ready;
  logic               i_packet_ongoing;

  modport master (
    output i_req, i_size, i_dat, i_write, i_link_ready, i_packet_ongoing,
    input  o_grant, o_ready, o_done, o_timeout,
    input  o_start_packet, o_packet_size, o_link_dat, o_link_write
  );

  modport slave (
    input  i_req, i_size, i_dat, i_write, i_link_ready, i_packet_ongoing,
    output o_grant, o_ready, o_done, o_timeout,
    output o_start_packet, o_packet_size, o_link_dat, o_link_write
  );

endinterface

// File: rtl/trng_rr_picker.sv
// Round-robin pick: first eligible index after last_grant, wrapping at N_REQ.
// Purely combinational, zero latency; no backpressure.
// Ports: eligible mask, last_grant index in; one-hot grant and valid out.
module trng_rr_picker #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [2:0]       last_grant,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    // Walk last_grant+1 .. last_grant+N_REQ so the previous owner comes last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int k = 0; k < N_REQ; k++) begin
        if (k == idx && !valid && eligible[k]) begin
          grant[k] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/trng_link_arbiter.sv
// Round-robin owner of the packet_com link: one packet per grant, bytes forwarded one at a time.
// Latency: grant 1 cycle after request, start 1 cycle later; each byte >= 2 cycles (accept, forward).
// Backpressure: o_ready is registered-state only, low while the hold byte waits for i_link_ready.
// Ports: i_clk, i_reset (async, active high), bus (trng_link_arbiter_if.slave).
// Build option TRNG_ARB_TIMEOUT_EN: a stalled owner is aborted after TIMEOUT_CYCLES and its
// remaining bytes are sent as 0x00, flagged by o_timeout.
module trng_link_arbiter
  import trng_link_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               i_clk,
  input  logic               i_reset,
  trng_link_arbiter_if.slave bus
);

  arb_state_t       state;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick_grant;
  logic [N_REQ-1:0] ready;
  logic             pick_valid;
  logic [6:0]       remaining;
  logic [6:0]       packet_size_q;
  logic [6:0]       win_size;
  logic [7:0]       hold;
  logic [7:0]       link_dat_q;
  logic [7:0]       acc_dat;
  logic             hold_valid;
  logic             start_q;
  logic             link_write_q;
  logic             accept;
  logic             timed_out;
  logic [2:0]       last_grant;
  logic [2:0]       owner_idx;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_REQ; k++) begin
      eligible[k] = bus.i_req[k] & size_ok(bus.i_size[k*7 +: 7]);
    end
  end

  trng_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_comb begin
    win_size  = '0;
    acc_dat   = '0;
    owner_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_grant[k]) win_size = bus.i_size[k*7 +: 7];
      if (grant_q[k]) begin
        acc_dat   = bus.i_dat[k*8 +: 8];
        owner_idx = 3'(k);
      end
    end
  end

  // Single-entry hold: accept only when both the hold and the link strobe are empty.
  assign ready  = (state == XFER && !hold_valid && !link_write_q &&
                   remaining != 7'd0 && !timed_out) ? grant_q : '0;
  assign accept = |(bus.i_write & ready);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      remaining     <= '0;
      packet_size_q <= '0;
      hold          <= '0;
      hold_valid    <= 1'b0;
      link_dat_q    <= '0;
      link_write_q  <= 1'b0;
      start_q       <= 1'b0;
      last_grant    <= 3'(N_REQ - 1);
    end else begin
      start_q      <= 1'b0;
      link_write_q <= 1'b0;
      done_q       <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q       <= pick_grant;
            remaining     <= win_size;
            packet_size_q <= win_size;
            state         <= START;
          end
        end
        START: begin
          start_q <= 1'b1;
          state   <= XFER;
        end
        XFER: begin
          if (hold_valid && bus.i_link_ready && !link_write_q) begin
            link_write_q <= 1'b1;
            link_dat_q   <= hold;
            hold_valid   <= 1'b0;
          end
          if (accept) begin
            hold       <= acc_dat;
            hold_valid <= 1'b1;
            remaining  <= remaining - 7'd1;
          end else if (timed_out && !hold_valid && !link_write_q && remaining != 7'd0) begin
            // Aborted packet: fill the frame with zeros through the normal path.
            hold       <= '0;
            hold_valid <= 1'b1;
            remaining  <= remaining - 7'd1;
          end
          if (remaining == 7'd0 && !hold_valid && !link_write_q) state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.i_packet_ongoing) begin
            done_q     <= grant_q;
            grant_q    <= '0;
            last_grant <= owner_idx;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRNG_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic [N_REQ-1:0]   timeout_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt <= '0;
      timed_out <= 1'b0;
      timeout_q <= '0;
    end else begin
      timeout_q <= '0;
      if (state == DRAIN && !bus.i_packet_ongoing) begin
        timeout_q <= timed_out ? grant_q : '0;
        timed_out <= 1'b0;
        stall_cnt <= '0;
      end else if (state == XFER && !timed_out) begin
        if (accept) begin
          stall_cnt <= '0;
        end else if (|ready) begin
          if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) timed_out <= 1'b1;
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timed_out          = 1'b0;
  assign bus.o_timeout      = '0;
`endif

  assign bus.o_grant        = grant_q;
  assign bus.o_ready        = ready;
  assign bus.o_done         = done_q;
  assign bus.o_start_packet = start_q;
  assign bus.o_packet_size  = packet_size_q;
  assign bus.o_link_dat     = link_dat_q;
  assign bus.o_link_write   = link_write_q;

endmodule

// File: tb/tb_trng_link_arbiter.sv
// Bench for trng_link_arbiter: producers with known byte streams, a small packet_com model,
// and a scoreboard applying the rotation, size and byte-order rules to what appears on the link.
module tb_trng_link_arbiter;

  localparam int N = 3;
`ifdef TRNG_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  trng_link_arbiter_if #(.N_REQ(N)) bus ();

  trng_link_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // producers
  logic [7:0] pbytes [N][128];
  int  psize [N];
  int  psent [N];
  int  stop_after [N];
  bit  preq [N];
  bit  cont [N];
  bit  elig [N];
  int  wr_pct, rdy_pct, fix_size;
  bit  rand_mode, force_low;
  // packet_com model
  bit  ongoing, link_rdy, prev_lw;
  int  close_dly, link_cnt;
  // scoreboard
  int  prev_owner, owner, grant_cyc, cyc, n_start, n_done, g0_seen;
  bit  busy;
  int  gorder [$];

  function automatic int onehot(input int i);
    return 1 << i;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int next_size();
    if (fix_size > 0) return fix_size;
    if ($urandom_range(0, 9) == 0) return 127;
    return int'($urandom_range(1, 12));
  endfunction

  task automatic new_packet(input int k, input int sz);
    psize[k] = sz;
    psent[k] = 0;
    for (int i = 0; i < 128; i++) pbytes[k][i] = 8'($urandom);
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      preq[k] = 0; cont[k] = 0; elig[k] = 0;
      psize[k] = 0; psent[k] = 0; stop_after[k] = 1000;
    end
    busy = 0; prev_owner = N - 1; owner = 0; ongoing = 0; close_dly = 0;
    link_cnt = 0; prev_lw = 0; link_rdy = 0; force_low = 0; rand_mode = 0;
    n_done = 0; n_start = 0; g0_seen = 0; fix_size = 0; wr_pct = 100; rdy_pct = 100;
    gorder.delete();
    bus.i_req = '0; bus.i_size = '0; bus.i_dat = '0; bus.i_write = '0;
    bus.i_link_ready = 1'b0; bus.i_packet_ongoing = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_grant"},  int'(bus.o_grant), 0);
    check_eq({pfx, "_ready"},  int'(bus.o_ready), 0);
    check_eq({pfx, "_done"},   int'(bus.o_done), 0);
    check_eq({pfx, "_tmo"},    int'(bus.o_timeout), 0);
    check_eq({pfx, "_start"},  int'(bus.o_start_packet), 0);
    check_eq({pfx, "_size"},   int'(bus.o_packet_size), 0);
    check_eq({pfx, "_ldat"},   int'(bus.o_link_dat), 0);
    check_eq({pfx, "_lwrite"}, int'(bus.o_link_write), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    model_clear();
    repeat (2) @(negedge i_clk);
    check_outputs_zero("rst");
    i_reset = 1'b0;
  endtask

  // One cycle: score what the last edge produced, then drive the next inputs.
  task automatic step();
    int w, a, eb;
    bit wr;
    @(negedge i_clk);
    cyc++;
    if (bus.o_grant[0]) g0_seen++;

    if (bus.o_done != '0) begin
      n_done++;
      check_eq("done_owner", int'(bus.o_done), busy ? onehot(owner) : 0);
      check_eq("done_bytes", link_cnt, psize[owner]);
      check_eq("done_link_idle", int'(ongoing), 0);
      check_eq("done_timeout", int'(bus.o_timeout),
               (psent[owner] < psize[owner]) ? onehot(owner) : 0);
      check_eq("done_grant_clr", int'(bus.o_grant), 0);
      busy = 0;
      prev_owner = owner;
      if (rand_mode ? ($urandom_range(0, 1) == 1) : cont[owner]) new_packet(owner, next_size());
      else preq[owner] = 0;
    end else if (busy) begin
      check_eq("grant_hold", int'(bus.o_grant), onehot(owner));
    end else if (bus.o_grant != '0) begin
      w = -1;
      for (int i = 1; i <= N; i++) if (w < 0 && elig[(prev_owner + i) % N]) w = (prev_owner + i) % N;
      check_eq("grant_rr", int'(bus.o_grant), (w >= 0) ? onehot(w) : 0);
      a = oh_idx(bus.o_grant);
      owner = (a >= 0) ? a : 0;
      busy = 1; grant_cyc = cyc; link_cnt = 0;
      gorder.push_back(owner);
    end

    if (bus.o_start_packet) begin
      n_start++;
      check_eq("start_latency", cyc - grant_cyc, 1);
      check_eq("start_link_idle", int'(ongoing), 0);
      check_eq("start_size", int'(bus.o_packet_size), psize[owner]);
      ongoing = 1;
    end

    check_eq("ready_owner", int'(bus.o_ready) & ~(busy ? onehot(owner) : 0), 0);

    if (bus.o_link_write) begin
      eb = (link_cnt < psent[owner] && link_cnt < 128) ? int'(pbytes[owner][link_cnt]) : 0;
      check_eq("link_dat", int'(bus.o_link_dat), eb);
      check_eq("link_rdy_seen", int'(link_rdy), 1);
      check_eq("link_single", int'(prev_lw), 0);
      link_cnt++;
      if (link_cnt == psize[owner]) close_dly = int'($urandom_range(1, 4));
    end
    prev_lw = bus.o_link_write;

    if (close_dly > 0) begin
      close_dly--;
      if (close_dly == 0) ongoing = 0;
    end
    link_rdy = force_low ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    for (int k = 0; k < N; k++) begin
      if (rand_mode && !preq[k] && $urandom_range(0, 7) == 0) begin
        preq[k] = 1;
        new_packet(k, next_size());
      end
      wr = preq[k] && psent[k] < psize[k] && psent[k] < stop_after[k] &&
           ($urandom_range(0, 99) < wr_pct);
      bus.i_req[k]         = preq[k];
      bus.i_size[k*7 +: 7] = 7'(psize[k]);
      bus.i_dat[k*8 +: 8]  = pbytes[k][(psent[k] < 128) ? psent[k] : 0];
      bus.i_write[k]       = wr;
      elig[k] = preq[k] && psize[k] != 0;
      if (wr && bus.o_ready[k]) psent[k]++;
    end
    bus.i_link_ready     = link_rdy;
    bus.i_packet_ongoing = ongoing;
  endtask

  task automatic run_dones(input string tag, input int target, input int budget);
    int c;
    c = 0;
    while (n_done < target && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, n_done, target);
  endtask

  initial begin
    int c;
    cyc = 0;
    grant_cyc = 0;

    // single requester, fixed bytes
    do_reset();
    preq[1] = 1; psize[1] = 3; psent[1] = 0;
    pbytes[1][0] = 8'hA5; pbytes[1][1] = 8'h5A; pbytes[1][2] = 8'hFF;
    run_dones("t1_done", 1, 200);
    check_eq("t1_starts", n_start, 1);
    check_eq("t1_owner", gorder[0], 1);
    check_eq("t1_accepted", psent[1], 3);

    // all three continuous, size 1: strict rotation from requester 0
    do_reset();
    fix_size = 1;
    for (int k = 0; k < N; k++) begin
      preq[k] = 1; cont[k] = 1; new_packet(k, 1);
    end
    run_dones("t2_done", 4, 400);
    check_eq("t2_order0", gorder[0], 0);
    check_eq("t2_order1", gorder[1], 1);
    check_eq("t2_order2", gorder[2], 2);
    check_eq("t2_order3", gorder[3], 0);

    // size-0 request masked
    do_reset();
    fix_size = 2;
    preq[0] = 1; psize[0] = 0;
    preq[2] = 1; cont[2] = 1; new_packet(2, 2);
    run_dones("t3_done", 2, 300);
    check_eq("t3_g0_never", g0_seen, 0);
    check_eq("t3_owner", gorder[1], 2);

    // link stalled 50 cycles mid-packet
    do_reset();
    preq[0] = 1; new_packet(0, 10);
    c = 0;
    while (link_cnt < 3 && c < 100) begin step(); c++; end
    check_eq("t4_reached", (link_cnt >= 3) ? 1 : 0, 1);
    force_low = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i >= 3) begin
        check_eq("t4_ready_low", int'(bus.o_ready), 0);
        check_eq("t4_no_write", int'(bus.o_link_write), 0);
      end
    end
    force_low = 0;
    run_dones("t4_done", 1, 200);

`ifdef TRNG_ARB_TIMEOUT_EN
    // owner stops after one byte: rest is zero-filled and flagged
    do_reset();
    preq[0] = 1; new_packet(0, 4); stop_after[0] = 1;
    run_dones("t5_done", 1, 500);
    check_eq("t5_accepted", psent[0], 1);
`endif

    // randomized traffic
    do_reset();
    rand_mode = 1; wr_pct = 60; rdy_pct = 70;
    run_dones("rand_done", 40, 40000);

    // asynchronous reset in the middle of a packet
    do_reset();
    preq[0] = 1; new_packet(0, 20); wr_pct = 50;
    c = 0;
    while (!(busy && link_cnt >= 2) && c < 300) begin step(); c++; end
    check_eq("t6_reached", (link_cnt >= 2) ? 1 : 0, 1);
    #2;
    i_reset = 1'b1;
    #1;
    check_outputs_zero("arst");
    model_clear();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    fix_size = 1;
    for (int k = 0; k < N; k++) begin
      preq[k] = 1; cont[k] = 1; new_packet(k, 1);
    end
    run_dones("t6_done", 3, 300);
    check_eq("t6_first_grant", gorder[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
